// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: ALU op codes, RV32I opcode constants,
// the issue packet carried through the skid buffer, and the skid FSM states.
package alu_pkg;

  localparam int ALU_XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [ALU_XLEN-1:0] op1;
    logic [ALU_XLEN-1:0] op2;
    alu_op_e             alu_op;
    logic [4:0]          rd;
    logic                rd_we;
    logic                illegal;
  } issue_pkt_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } skid_state_e;

  // funct3 -> ALU op; alt selects SUB/SRA for the funct3 codes that have one.
  function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_skid.sv
// Two-entry skid buffer for issue packets: main register drives the outputs,
// skid register catches the entry accepted while the consumer stalls.
module alu_issue_skid
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  issue_pkt_t in_pkt,
  output logic       out_valid,
  input  logic       out_ready,
  output issue_pkt_t out_pkt
);

  skid_state_e state, state_nxt;
  issue_pkt_t  main_q, skid_q;
  logic        load_main, load_skid, main_from_skid;
  logic        accept, consume;

  // Ready depends only on registered state so it never combinationally loops upstream.
  assign in_ready  = (state != S_TWO);
  assign out_valid = (state != S_EMPTY);
  assign out_pkt   = main_q;

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            state_nxt = S_ONE;
            load_main = 1'b1;
          end
        end
        S_ONE: begin
          if (accept && consume) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_nxt = S_TWO;
            load_skid = 1'b1;
          end else if (consume) begin
            state_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          if (consume) begin
            state_nxt      = S_ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      if (load_main) main_q <= main_from_skid ? skid_q : in_pkt;
      if (load_skid) skid_q <= in_pkt;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// RV32I ALU-class decode/issue: builds operands and ALU op from the instruction,
// then hands the packet to a 2-entry skid buffer facing the execute stage.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = ALU_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [3:0]      alu_op,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            illegal
);

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd_idx;
  logic        legal;
  issue_pkt_t  dec_pkt, out_pkt;
  logic        unused_rs1_idx;

  assign opcode = instr[6:0];
  assign rd_idx = instr[11:7];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  // Source indices are resolved by the register file; only their data arrives here.
  assign unused_rs1_idx = ^instr[19:15];

  always_comb begin
    dec_pkt        = '0;
    legal          = 1'b0;
    dec_pkt.alu_op = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        dec_pkt.op1 = rs1_data;
        dec_pkt.op2 = rs2_data;
        if (f7 == F7_BASE) begin
          legal          = 1'b1;
          dec_pkt.alu_op = f3_to_op(f3, 1'b0);
        end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
          legal          = 1'b1;
          dec_pkt.alu_op = f3_to_op(f3, 1'b1);
        end
      end
      OPC_OP_IMM: begin
        dec_pkt.op1 = rs1_data;
        dec_pkt.op2 = XLEN'($signed(instr[31:20]));
        case (f3)
          3'b001:  legal = (f7 == F7_BASE);
          3'b101:  legal = (f7 == F7_BASE) || (f7 == F7_ALT);
          default: legal = 1'b1;
        endcase
        // Only the shift-right encoding has an alternate form; ADDI never becomes SUB.
        dec_pkt.alu_op = f3_to_op(f3, (f3 == 3'b101) && (f7 == F7_ALT));
      end
      OPC_LUI: begin
        legal       = 1'b1;
        dec_pkt.op2 = XLEN'($signed({instr[31:12], 12'b0}));
      end
      OPC_AUIPC: begin
        legal       = 1'b1;
        dec_pkt.op1 = pc;
        dec_pkt.op2 = XLEN'($signed({instr[31:12], 12'b0}));
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec_pkt.op1    = '0;
      dec_pkt.op2    = '0;
      dec_pkt.alu_op = ALU_ADD;
    end
    dec_pkt.rd      = rd_idx;
    dec_pkt.rd_we   = legal && (rd_idx != 5'd0);
    dec_pkt.illegal = !legal;
  end

  alu_issue_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pkt    (dec_pkt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pkt   (out_pkt)
  );

  assign op1     = out_pkt.op1;
  assign op2     = out_pkt.op2;
  assign alu_op  = out_pkt.alu_op;
  assign rd      = out_pkt.rd;
  assign rd_we   = out_pkt.rd_we;
  assign illegal = out_pkt.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, backpressure ordering,
// flush and reset behaviour, all with hand-computed expectations.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid, rd_we, illegal;
  logic [31:0] instr, pc, rs1_data, rs2_data, op1, op2;
  logic [3:0]  alu_op;
  logic [4:0]  rd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op1       (op1),
    .op2       (op2),
    .alu_op    (alu_op),
    .rd        (rd),
    .rd_we     (rd_we),
    .illegal   (illegal)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = 32'h0; pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_op1", op1, 0);

    // ADD x3,x1,x2
    in_valid = 1'b1; instr = 32'h002081B3; rs1_data = 32'd5; rs2_data = 32'd7;
    tick();
    check("add_valid", out_valid, 1);
    check("add_op1", op1, 5);
    check("add_op2", op2, 7);
    check("add_aluop", alu_op, 0);
    check("add_rd", rd, 3);
    check("add_rdwe", rd_we, 1);
    check("add_illegal", illegal, 0);

    // SRAI x4,x1,3
    instr = 32'h4030D213;
    tick();
    check("srai_op2", op2[4:0], 3);
    check("srai_aluop", alu_op, 7);
    check("srai_rd", rd, 4);
    check("srai_illegal", illegal, 0);

    // SLLI with funct7=0100000 is illegal
    instr = 32'h40309213;
    tick();
    check("slli_bad_illegal", illegal, 1);
    check("slli_bad_rdwe", rd_we, 0);
    check("slli_bad_op1", op1, 0);
    check("slli_bad_aluop", alu_op, 0);

    // AUIPC x5,0x12345 at pc 0x100
    instr = 32'h12345297; pc = 32'h100;
    tick();
    check("auipc_op1", op1, 32'h100);
    check("auipc_op2", op2, 32'h12345000);
    check("auipc_aluop", alu_op, 0);
    check("auipc_rd", rd, 5);

    // LUI x6,0xABCDE
    instr = 32'hABCDE337;
    tick();
    check("lui_op1", op1, 0);
    check("lui_op2", op2, 32'hABCDE000);
    check("lui_rdwe", rd_we, 1);

    // ADDI x0,x1,1: legal but no write-back
    instr = 32'h00108013;
    tick();
    check("addi_x0_rdwe", rd_we, 0);
    check("addi_x0_illegal", illegal, 0);
    check("addi_x0_op1", op1, 5);
    check("addi_x0_op2", op2, 1);

    // SUB x7,x1,x2
    instr = 32'h402083B3;
    tick();
    check("sub_aluop", alu_op, 1);
    check("sub_rd", rd, 7);

    // R-type funct7=0100000 funct3=001 is illegal
    instr = 32'h402091B3;
    tick();
    check("r_bad_illegal", illegal, 1);
    check("r_bad_op2", op2, 0);

    in_valid = 1'b0;
    tick();
    check("drain_valid", out_valid, 0);

    // Backpressure: three back-to-back ADDIs with out_ready low
    out_ready = 1'b0; rs1_data = 32'h0;
    in_valid = 1'b1; instr = 32'h01100093;
    tick();
    check("bp_a_valid", out_valid, 1);
    check("bp_a_ready", in_ready, 1);
    instr = 32'h02200113;
    tick();
    check("bp_b_ready", in_ready, 0);
    check("bp_b_hold", op2, 32'h11);
    instr = 32'h03300193;
    tick();
    check("bp_c_ready", in_ready, 0);
    check("bp_c_hold", op2, 32'h11);
    out_ready = 1'b1;
    tick();
    check("bp_second", op2, 32'h22);
    check("bp_second_rd", rd, 2);
    check("bp_second_ready", in_ready, 1);
    tick();
    check("bp_third", op2, 32'h33);
    check("bp_third_rd", rd, 3);
    in_valid = 1'b0;
    tick();
    check("bp_empty", out_valid, 0);

    // Flush while TWO with a new input offered
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h01100093;
    tick();
    instr = 32'h02200113;
    tick();
    check("fl_two_ready", in_ready, 0);
    instr = 32'h03300193; flush = 1'b1;
    tick();
    check("fl_valid", out_valid, 0);
    check("fl_ready", in_ready, 1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("fl_no_ghost", out_valid, 0);

    // Reset while holding one entry
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h01100093;
    tick();
    check("rst1_valid", out_valid, 1);
    rst = 1'b1; in_valid = 1'b0;
    tick();
    check("rst1_cleared_valid", out_valid, 0);
    check("rst1_cleared_op2", op2, 0);
    check("rst1_ready", in_ready, 1);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
